// File: rtl/peripheral_mpram_wb.sv
// peripheral_mpram_wb: multi-port Wishbone RAM, round-robin arbitration, registered-feedback bursts.
// Optional PERIPHERAL_MPRAM_WB_ERR_EN: err on reserved cti and on linear bursts passing the top of memory.
module peripheral_mpram_wb #(
   parameter int CORES = 2,
   parameter int DEPTH = 1024,
   parameter int DW    = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic [CORES*AW-1:0]   wb_adr_i,
   input  logic [CORES*DW-1:0]   wb_dat_i,
   input  logic [CORES*DW/8-1:0] wb_sel_i,
   input  logic [CORES-1:0]      wb_we_i,
   input  logic [CORES-1:0]      wb_cyc_i,
   input  logic [CORES-1:0]      wb_stb_i,
   input  logic [CORES*3-1:0]    wb_cti_i,
   input  logic [CORES*2-1:0]    wb_bte_i,
   output logic [CORES*DW-1:0]   wb_dat_o,
   output logic [CORES-1:0]      wb_ack_o,
   output logic [CORES-1:0]      wb_err_o
);
   localparam int WW = AW - 2;
   localparam int GW = (CORES > 1) ? $clog2(CORES) : 1;
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state_q, state_d;
   logic [GW-1:0] grant_q, grant_d, ptr_q, ptr_d, idx;
   logic [WW-1:0] adr_q, adr_d, cur, nxt, mask;
   logic beat_q, beat_d;
   logic [CORES-1:0] ack_q, ack_d, err_q, err_d, req;
   logic [CORES*DW-1:0] dat_q, dat_d;
   logic [DW-1:0] mem [DEPTH/4];
   logic [DW-1:0] wdat, rdata;
   logic [DW/8-1:0] sel;
   logic [2:0] cti;
   logic [1:0] bte;
   logic cyc, stb, we, hit, fail, wr;
   assign req = wb_cyc_i & wb_stb_i;
   always_comb begin
      cyc   = wb_cyc_i[grant_q];
      stb   = wb_stb_i[grant_q];
      we    = wb_we_i[grant_q];
      sel   = wb_sel_i[grant_q*(DW/8) +: DW/8];
      cti   = wb_cti_i[grant_q*3 +: 3];
      bte   = wb_bte_i[grant_q*2 +: 2];
      wdat  = wb_dat_i[grant_q*DW +: DW];
      cur   = beat_q ? adr_q : wb_adr_i[grant_q*AW+2 +: WW];
      // wrap bursts advance only the low bits of the word index
      mask  = (bte == 2'd1) ? WW'(3) : (bte == 2'd2) ? WW'(7) : (bte == 2'd3) ? WW'(15) : {WW{1'b1}};
      nxt   = (cur & ~mask) | ((cur + 1'b1) & mask);
      for (int b = 0; b < DW/8; b++)
         rdata[b*8 +: 8] = (we && sel[b]) ? wdat[b*8 +: 8] : mem[cur][b*8 +: 8];
`ifdef PERIPHERAL_MPRAM_WB_ERR_EN
      fail  = (cti != 3'b000 && cti != 3'b010 && cti != 3'b111) || (beat_q && bte == 2'd0 && adr_q == '0);
`else
      fail  = 1'b0;
`endif
      hit   = state_q == BUSY && cyc && stb;
      wr    = hit && !fail && we && !wb_rst_i;
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      adr_d   = adr_q;
      beat_d  = beat_q;
      ack_d   = '0;
      err_d   = '0;
      dat_d   = '0;
      idx     = '0;
      if (state_q == IDLE) begin
         beat_d = 1'b0;
         for (int i = CORES-1; i >= 0; i--) begin
            idx = GW'((int'(ptr_q) + i) % CORES);
            if (req[idx]) grant_d = idx;
         end
         if (|req) begin
            state_d = BUSY;
            ptr_d   = GW'((int'(grant_d) + 1) % CORES);
         end
      end else if (!cyc) begin
         state_d = IDLE;
      end else if (hit && fail) begin
         err_d[grant_q] = 1'b1;
         state_d        = IDLE;
      end else if (hit) begin
         ack_d[grant_q]             = 1'b1;
         dat_d[grant_q*DW +: DW]    = rdata;
         adr_d                      = nxt;
         beat_d                     = 1'b1;
         state_d                    = (cti == 3'b010) ? BUSY : IDLE;
      end
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         adr_q   <= '0;
         beat_q  <= 1'b0;
         ack_q   <= '0;
         err_q   <= '0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         adr_q   <= adr_d;
         beat_q  <= beat_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
      end
   end
   always_ff @(posedge wb_clk_i)
      if (wr)
         for (int b = 0; b < DW/8; b++)
            if (sel[b]) mem[cur][b*8 +: 8] <= wdat[b*8 +: 8];
   assign wb_ack_o = ack_q & wb_cyc_i;
   assign wb_err_o = err_q & wb_cyc_i;
   assign wb_dat_o = dat_q;
endmodule

// File: tb/tb_peripheral_mpram_wb.sv
// tb_peripheral_mpram_wb: randomized self-checking bench against a byte-array model of the shared RAM.
module tb_peripheral_mpram_wb;
   localparam int CORES = 2, DEPTH = 1024, DW = 32, AW = 10, WORDS = DEPTH/4;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic [AW-1:0] adr_r [CORES];
   logic [DW-1:0] dat_r [CORES];
   logic [3:0]    sel_r [CORES];
   logic [2:0]    cti_r [CORES];
   logic [1:0]    bte_r [CORES];
   logic [CORES-1:0] we_r = '0, cyc_r = '0, stb_r = '0;
   logic [CORES*AW-1:0] wb_adr;
   logic [CORES*DW-1:0] wb_dat, wb_dat_o;
   logic [CORES*4-1:0]  wb_sel;
   logic [CORES*3-1:0]  wb_cti;
   logic [CORES*2-1:0]  wb_bte;
   logic [CORES-1:0]    wb_ack_o, wb_err_o;
   genvar g;
   for (g = 0; g < CORES; g++) begin : g_pack
      assign wb_adr[g*AW +: AW] = adr_r[g];
      assign wb_dat[g*DW +: DW] = dat_r[g];
      assign wb_sel[g*4 +: 4]   = sel_r[g];
      assign wb_cti[g*3 +: 3]   = cti_r[g];
      assign wb_bte[g*2 +: 2]   = bte_r[g];
   end
   peripheral_mpram_wb #(.CORES(CORES), .DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
      .wb_we_i(we_r), .wb_cyc_i(cyc_r), .wb_stb_i(stb_r), .wb_cti_i(wb_cti), .wb_bte_i(wb_bte),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o));

   logic [7:0] ref_mem [DEPTH];
   int checks = 0, errors = 0;
   int last_p = CORES-1;

   function automatic logic [31:0] ref_word(input int w);
      return {ref_mem[w*4+3], ref_mem[w*4+2], ref_mem[w*4+1], ref_mem[w*4]};
   endfunction
   function automatic void ref_write(input int w, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[w*4+b] = d[b*8 +: 8];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic classic(input int p, input logic w, input int word, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r, output int lat);
      adr_r[p] = AW'(word * 4); dat_r[p] = d; sel_r[p] = s; cti_r[p] = 3'b000; bte_r[p] = 2'b00;
      we_r[p] = w; cyc_r[p] = 1'b1; stb_r[p] = 1'b1;
      lat = 0; r = '0;
      do begin tick; lat++; end while (!wb_ack_o[p] && lat < 20);
      if (wb_ack_o[p]) begin
         r = wb_dat_o[p*DW +: DW];
         last_p = p;
         if (w) ref_write(word, d, s);
      end
      cyc_r[p] = 1'b0; stb_r[p] = 1'b0; we_r[p] = 1'b0;
   endtask

   task automatic burst(input int p, input logic w, input int word, input logic [1:0] bt, input int n,
                        input int gap_after, input int gap_len, input logic [31:0] wd [16],
                        output logic [31:0] rd [16], output int acks, output int errs,
                        output int gap_acks, output int cnt);
      acks = 0; errs = 0; gap_acks = 0; cnt = 0;
      for (int i = 0; i < 16; i++) rd[i] = '0;
      adr_r[p] = AW'(word * 4); bte_r[p] = bt; we_r[p] = w; sel_r[p] = 4'hF; dat_r[p] = wd[0];
      cti_r[p] = (n == 1) ? 3'b111 : 3'b010; cyc_r[p] = 1'b1; stb_r[p] = 1'b1;
      while (acks < n && errs == 0 && cnt < 100) begin
         tick; cnt++;
         if (wb_err_o[p]) errs++;
         else if (wb_ack_o[p]) begin
            rd[acks] = wb_dat_o[p*DW +: DW];
            acks++;
            dat_r[p] = wd[acks % 16];
            cti_r[p] = (acks == n-1) ? 3'b111 : 3'b010;
            if (acks == gap_after) begin
               stb_r[p] = 1'b0;
               repeat (gap_len) begin tick; cnt++; if (wb_ack_o[p]) gap_acks++; end
               stb_r[p] = 1'b1;
            end
         end
      end
      if (acks > 0 || errs > 0) last_p = p;
      cyc_r[p] = 1'b0; stb_r[p] = 1'b0; we_r[p] = 1'b0; cti_r[p] = 3'b000; bte_r[p] = 2'b00;
   endtask

   task automatic pair(input int w0, input int w1, output int c0, output int c1,
                       output logic [31:0] r0, output logic [31:0] r1, output int leak);
      for (int p = 0; p < 2; p++) begin
         cti_r[p] = 3'b000; bte_r[p] = 2'b00; we_r[p] = 1'b0; sel_r[p] = 4'hF;
         cyc_r[p] = 1'b1; stb_r[p] = 1'b1;
      end
      adr_r[0] = AW'(w0 * 4); adr_r[1] = AW'(w1 * 4);
      c0 = 0; c1 = 0; leak = 0; r0 = '0; r1 = '0;
      for (int t = 1; t <= 20 && (c0 == 0 || c1 == 0); t++) begin
         tick;
         if (wb_ack_o[0] && c0 == 0) begin
            c0 = t; r0 = wb_dat_o[31:0];
            if (wb_ack_o[1] || wb_dat_o[63:32] != '0) leak++;
            cyc_r[0] = 1'b0; stb_r[0] = 1'b0;
         end else if (wb_ack_o[1] && c1 == 0) begin
            c1 = t; r1 = wb_dat_o[63:32];
            if (wb_ack_o[0] || wb_dat_o[31:0] != '0) leak++;
            cyc_r[1] = 1'b0; stb_r[1] = 1'b0;
         end
      end
      cyc_r = '0; stb_r = '0;
      last_p = (c0 > c1) ? 0 : 1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) tick;
      checks++; if (wb_ack_o !== '0) begin errors++; $display("FAIL reset_ack got %b exp 0", wb_ack_o); end
      checks++; if (wb_err_o !== '0) begin errors++; $display("FAIL reset_err got %b exp 0", wb_err_o); end
      checks++; if (wb_dat_o !== '0) begin errors++; $display("FAIL reset_dat got %h exp 0", wb_dat_o); end
      rst = 1'b0;
      tick;
      last_p = CORES-1;
   endtask

   task automatic test_init;
      logic [31:0] r;
      int lat;
      for (int w = 0; w < WORDS; w++) classic(0, 1'b1, w, $urandom, 4'hF, r, lat);
   endtask

   task automatic test_basic;
      logic [31:0] r;
      int lat;
      classic(0, 1'b1, 4, 32'hDEADBEEF, 4'hF, r, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL basic_wr_latency got %0d exp 2", lat); end
      classic(0, 1'b0, 4, '0, 4'hF, r, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL basic_rd_latency got %0d exp 2", lat); end
      checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data got %h exp deadbeef", r); end
   endtask

   task automatic test_byte_lanes;
      logic [31:0] r;
      int lat;
      classic(1, 1'b1, 8, 32'h11223344, 4'hF, r, lat);
      classic(1, 1'b1, 8, 32'hAABBCCDD, 4'b0101, r, lat);
      classic(0, 1'b0, 8, '0, 4'hF, r, lat);
      checks++; if (r !== 32'h11BB33DD) begin errors++; $display("FAIL byte_lanes got %h exp 11bb33dd", r); end
      checks++; if (r !== ref_word(8)) begin errors++; $display("FAIL byte_lanes_model got %h exp %h", r, ref_word(8)); end
   endtask

   task automatic test_contention;
      logic [31:0] r, r0, r1;
      int lat, c0, c1, leak, first, w0, w1;
      classic(1, 1'b0, 3, '0, 4'hF, r, lat);
      for (int k = 0; k < 2; k++) begin
         w0 = $urandom_range(0, WORDS-1); w1 = $urandom_range(0, WORDS-1);
         first = (last_p + 1) % CORES;
         pair(w0, w1, c0, c1, r0, r1, leak);
         checks++; if ((first == 0 ? c0 : c1) !== 2) begin errors++; $display("FAIL contention_first pair %0d port %0d ack cycle got %0d exp 2", k, first, first == 0 ? c0 : c1); end
         checks++; if ((first == 0 ? c1 : c0) !== 4) begin errors++; $display("FAIL contention_second pair %0d ack cycle got %0d exp 4", k, first == 0 ? c1 : c0); end
         checks++; if (r0 !== ref_word(w0) || r1 !== ref_word(w1)) begin errors++; $display("FAIL contention_data got %h %h exp %h %h", r0, r1, ref_word(w0), ref_word(w1)); end
         checks++; if (leak !== 0) begin errors++; $display("FAIL contention_isolation got %0d exp 0", leak); end
      end
   endtask

   task automatic test_wrap4;
      logic [31:0] wd [16], rd [16], r;
      int acks, errs, ga, cnt, lat;
      for (int i = 0; i < 16; i++) wd[i] = '0;
      for (int w = 4; w < 8; w++) classic(1, 1'b1, w, $urandom, 4'hF, r, lat);
      burst(0, 1'b0, 6, 2'b01, 4, -1, 0, wd, rd, acks, errs, ga, cnt);
      checks++; if (acks !== 4) begin errors++; $display("FAIL wrap4_acks got %0d exp 4", acks); end
      checks++; if (cnt !== 5) begin errors++; $display("FAIL wrap4_cycles got %0d exp 5", cnt); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd[i] !== ref_word(4 + (2 + i) % 4)) begin errors++; $display("FAIL wrap4_beat%0d got %h exp %h", i, rd[i], ref_word(4 + (2 + i) % 4)); end
      end
      classic(1, 1'b0, 5, '0, 4'hF, r, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL wrap4_release latency got %0d exp 2", lat); end
   endtask

   task automatic test_linear_gap;
      logic [31:0] wd [16], rd [16], r, old0;
      int acks, errs, ga, cnt, lat, wexp [3];
      wexp = '{254, 255, 0};
      for (int i = 0; i < 16; i++) wd[i] = $urandom;
      old0 = ref_word(0);
      burst(0, 1'b1, 254, 2'b00, 3, 1, 2, wd, rd, acks, errs, ga, cnt);
      checks++; if (ga !== 0) begin errors++; $display("FAIL gap_ack got %0d exp 0", ga); end
`ifdef PERIPHERAL_MPRAM_WB_ERR_EN
      checks++; if (acks !== 2 || errs !== 1) begin errors++; $display("FAIL linear_top_err acks %0d errs %0d exp 2 1", acks, errs); end
      for (int i = 0; i < 2; i++) ref_write(wexp[i], wd[i], 4'hF);
`else
      checks++; if (acks !== 3 || errs !== 0) begin errors++; $display("FAIL linear_wrap acks %0d errs %0d exp 3 0", acks, errs); end
      for (int i = 0; i < 3; i++) ref_write(wexp[i], wd[i], 4'hF);
`endif
      for (int i = 0; i < 3; i++) begin
         classic(1, 1'b0, wexp[i], '0, 4'hF, r, lat);
         checks++;
         if (r !== ref_word(wexp[i])) begin errors++; $display("FAIL linear_word%0d got %h exp %h", wexp[i], r, ref_word(wexp[i])); end
      end
`ifdef PERIPHERAL_MPRAM_WB_ERR_EN
      checks++; if (ref_word(0) !== old0 || r !== old0) begin errors++; $display("FAIL linear_word0_kept got %h exp %h", r, old0); end
`endif
   endtask

   task automatic test_random;
      logic [31:0] wd [16], rd [16], r, d;
      int lat, p, word, acks, errs, ga, cnt, n, len, w0, ea;
      logic w;
      logic [1:0] bt;
      for (int i = 0; i < 16; i++) wd[i] = '0;
      for (int it = 0; it < 30; it++) begin
         p = $urandom_range(0, CORES-1); w = 1'($urandom_range(0, 1));
         word = $urandom_range(0, WORDS-1); d = $urandom;
         classic(p, w, word, d, 4'($urandom_range(0, 15)), r, lat);
         checks++; if (lat !== 2) begin errors++; $display("FAIL rand_latency it %0d got %0d exp 2", it, lat); end
         if (!w) begin
            checks++;
            if (r !== ref_word(word)) begin errors++; $display("FAIL rand_read it %0d got %h exp %h", it, r, ref_word(word)); end
         end
      end
      for (int it = 0; it < 6; it++) begin
         bt = 2'($urandom_range(0, 3));
         len = 2 << bt;
         n = (bt == 2'd0) ? $urandom_range(2, 8) : len;
         w0 = (bt == 2'd0) ? $urandom_range(0, WORDS-1-n) : $urandom_range(0, WORDS-1);
         p = $urandom_range(0, CORES-1);
         burst(p, 1'b0, w0, bt, n, -1, 0, wd, rd, acks, errs, ga, cnt);
         checks++; if (acks !== n || cnt !== n+1) begin errors++; $display("FAIL rand_burst it %0d acks %0d cycles %0d exp %0d %0d", it, acks, cnt, n, n+1); end
         for (int i = 0; i < n; i++) begin
            ea = (bt == 2'd0) ? w0 + i : (w0 - w0 % len) + (w0 % len + i) % len;
            checks++;
            if (rd[i] !== ref_word(ea)) begin errors++; $display("FAIL rand_burst it %0d beat %0d got %h exp %h", it, i, rd[i], ref_word(ea)); end
         end
      end
   endtask

   task automatic test_reset_burst;
      logic [31:0] r, r0, r1, b1;
      int lat, cnt, c0, c1, leak;
      for (int w = 32; w < 35; w++) classic(1, 1'b1, w, $urandom, 4'hF, r, lat);
      b1 = $urandom;
      adr_r[0] = AW'(32 * 4); dat_r[0] = b1; sel_r[0] = 4'hF; cti_r[0] = 3'b010; bte_r[0] = 2'b00;
      we_r[0] = 1'b1; cyc_r[0] = 1'b1; stb_r[0] = 1'b1;
      cnt = 0;
      do begin tick; cnt++; end while (!wb_ack_o[0] && cnt < 20);
      checks++; if (cnt !== 2) begin errors++; $display("FAIL rstburst_first_ack cycle got %0d exp 2", cnt); end
      ref_write(32, b1, 4'hF);
      dat_r[0] = ~b1; rst = 1'b1;
      tick;
      checks++; if (wb_ack_o[0] !== 1'b0) begin errors++; $display("FAIL rstburst_ack got %b exp 0", wb_ack_o[0]); end
      rst = 1'b0; cyc_r[0] = 1'b0; stb_r[0] = 1'b0; we_r[0] = 1'b0; cti_r[0] = 3'b000;
      last_p = CORES-1;
      tick;
      pair(32, 33, c0, c1, r0, r1, leak);
      checks++; if (c0 !== 2 || c1 !== 4) begin errors++; $display("FAIL rstburst_grant port0 %0d port1 %0d exp 2 4", c0, c1); end
      checks++; if (r0 !== ref_word(32)) begin errors++; $display("FAIL rstburst_beat1 got %h exp %h", r0, ref_word(32)); end
      checks++; if (r1 !== ref_word(33)) begin errors++; $display("FAIL rstburst_beat2 got %h exp %h", r1, ref_word(33)); end
      classic(0, 1'b0, 34, '0, 4'hF, r, lat);
      checks++; if (r !== ref_word(34)) begin errors++; $display("FAIL rstburst_beat3 got %h exp %h", r, ref_word(34)); end
   endtask

   initial begin
      for (int p = 0; p < CORES; p++) begin
         adr_r[p] = '0; dat_r[p] = '0; sel_r[p] = '0; cti_r[p] = '0; bte_r[p] = '0;
      end
      test_reset;
      test_init;
      test_basic;
      test_byte_lanes;
      test_contention;
      test_wrap4;
      test_linear_gap;
      test_random;
      test_reset_burst;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
      $fatal(1);
   end
endmodule
